// File: rtl/stream_fifo_pkg.sv
// Shared widths and helpers for stream_fifo_1w1rs.
// Pointers carry one wrap bit above the RAM address.
package stream_fifo_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int WIDTH_DEF = 32;

  function automatic int ptr_width(int depth);
    return $clog2(depth) + 1;
  endfunction

  // RAM entries plus the output stage, 0..DEPTH+1
  function automatic int occ_width(int depth);
    return $clog2(depth + 2);
  endfunction

  localparam int OCC_W_DEF = occ_width(DEPTH_DEF);

endpackage

// File: rtl/stream_fifo_1w1rs_ram.sv
// Ram_1w_1rs: one write port, one enable-gated registered read port.
// Contents are not reset; read-under-write is don't-care.
module Ram_1w_1rs #(
  parameter int wordCount      = 16,
  parameter int wordWidth      = 32,
  parameter int clockCrossing  = 0,
  parameter int wrMaskWidth    = 1,
  parameter int wrMaskEnable   = 0,
  parameter int wrAddressWidth = 4,
  parameter int wrDataWidth    = 32,
  parameter int rdAddressWidth = 4,
  parameter int rdDataWidth    = 32
) (
  input  logic                      wr_clk,
  input  logic                      wr_en,
  input  logic [wrMaskWidth-1:0]    wr_mask,
  input  logic [wrAddressWidth-1:0] wr_addr,
  input  logic [wrDataWidth-1:0]    wr_data,
  input  logic                      rd_clk,
  input  logic                      rd_en,
  input  logic [rdAddressWidth-1:0] rd_addr,
  output logic [rdDataWidth-1:0]    rd_data
);

  logic [wordWidth-1:0] mem [wordCount];
  logic                 wr_ok;
  logic                 rclk;

  assign wr_ok = wr_en && (wrMaskEnable == 0 || wr_mask[0]);
  assign rclk  = (clockCrossing != 0) ? rd_clk : wr_clk;

  always_ff @(posedge wr_clk) begin
    if (wr_ok)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge rclk) begin
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stream_fifo_1w1rs.sv
// Valid/ready FIFO whose RAM read register is the pop stage.
// Define STREAM_FIFO_OCCUPANCY_EN to add the occupancy port.
module stream_fifo_1w1rs
  import stream_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_payload,
  output logic             pop_valid,
  input  logic             pop_ready,
`ifdef STREAM_FIFO_OCCUPANCY_EN
  output logic [occ_width(DEPTH)-1:0] occupancy,
`endif
  output logic [WIDTH-1:0] pop_payload
);

  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          ram_empty;
  logic          ram_full;
  logic          push_fire;
  logic          rd_en;

  assign ram_empty  = wptr == rptr;
  assign ram_full   = (wptr[AW] != rptr[AW]) &&
                      (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_ready = !ram_full;
  assign push_fire  = push_valid && push_ready;
  // a stalled output stage blocks reads so rd_data holds
  assign rd_en      = !ram_empty && (!pop_valid || pop_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      pop_valid <= 1'b0;
    end else begin
      if (push_fire)
        wptr <= wptr + PW'(1);
      if (rd_en)
        rptr <= rptr + PW'(1);
      if (rd_en)
        pop_valid <= 1'b1;
      else if (pop_ready)
        pop_valid <= 1'b0;
    end
  end

`ifdef STREAM_FIFO_OCCUPANCY_EN
  localparam int OW = occ_width(DEPTH);

  logic pop_fire;

  assign pop_fire = pop_valid && pop_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy <= '0;
    end else begin
      unique case ({push_fire, pop_fire})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end
`endif

  Ram_1w_1rs #(
    .wordCount      (DEPTH),
    .wordWidth      (WIDTH),
    .clockCrossing  (0),
    .wrMaskWidth    (1),
    .wrMaskEnable   (0),
    .wrAddressWidth (AW),
    .wrDataWidth    (WIDTH),
    .rdAddressWidth (AW),
    .rdDataWidth    (WIDTH)
  ) u_ram (
    .wr_clk  (clk),
    .wr_en   (push_fire),
    .wr_mask (1'b1),
    .wr_addr (wptr[AW-1:0]),
    .wr_data (push_payload),
    .rd_clk  (clk),
    .rd_en   (rd_en),
    .rd_addr (rptr[AW-1:0]),
    .rd_data (pop_payload)
  );

endmodule

// File: tb/tb_stream_fifo_1w1rs.sv
// Bench for stream_fifo_1w1rs: DEPTH=16 directed, DEPTH=4 random,
// both against a queue-level reference model.
module tb_stream_fifo_1w1rs;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   sel = 1'b0;

  logic        s_pv = 1'b0;
  logic        s_pr = 1'b0;
  logic [31:0] s_pd = '0;

  logic        a_pv, a_pr, a_prdy, a_ov;
  logic [31:0] a_pd, a_od;
  logic        b_pv, b_pr, b_prdy, b_ov;
  logic [31:0] b_pd, b_od;

  logic        o_ov, o_prdy;
  logic [31:0] o_od;

  int checks = 0;
  int errors = 0;
  int dpops  = 0;

  always #5 clk = ~clk;

  assign a_pv = !sel && s_pv;
  assign a_pr = !sel && s_pr;
  assign a_pd = s_pd;
  assign b_pv = sel && s_pv;
  assign b_pr = sel && s_pr;
  assign b_pd = s_pd;

  assign o_ov   = sel ? b_ov : a_ov;
  assign o_od   = sel ? b_od : a_od;
  assign o_prdy = sel ? b_prdy : a_prdy;

`ifdef STREAM_FIFO_OCCUPANCY_EN
  logic [4:0] a_occ;
  logic [2:0] b_occ;
  int         o_occ;
  assign o_occ = sel ? int'(b_occ) : int'(a_occ);
`endif

  stream_fifo_1w1rs #(.DEPTH(16), .WIDTH(32)) u_dut16 (
    .clk          (clk),
    .reset        (reset),
    .push_valid   (a_pv),
    .push_ready   (a_prdy),
    .push_payload (a_pd),
    .pop_valid    (a_ov),
    .pop_ready    (a_pr),
`ifdef STREAM_FIFO_OCCUPANCY_EN
    .occupancy    (a_occ),
`endif
    .pop_payload  (a_od)
  );

  stream_fifo_1w1rs #(.DEPTH(4), .WIDTH(32)) u_dut4 (
    .clk          (clk),
    .reset        (reset),
    .push_valid   (b_pv),
    .push_ready   (b_prdy),
    .push_payload (b_pd),
    .pop_valid    (b_ov),
    .pop_ready    (b_pr),
`ifdef STREAM_FIFO_OCCUPANCY_EN
    .occupancy    (b_occ),
`endif
    .pop_payload  (b_od)
  );

  // reference: RAM as a queue plus one output-stage slot
  logic [31:0] mq[$];
  logic [31:0] gold[$];
  bit          mov = 1'b0;
  logic [31:0] mod = '0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  depth;
    bit  acc;
    bit  iss;
    depth = sel ? 4 : 16;
    acc = s_pv && (mq.size() < depth);
    iss = (mq.size() > 0) && (!mov || s_pr);
    if (iss) begin
      mov = 1'b1;
      mod = mq.pop_front();
    end else if (s_pr) begin
      mov = 1'b0;
    end
    if (acc) begin
      mq.push_back(s_pd);
      gold.push_back(s_pd);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    gold.delete();
    mov = 1'b0;
  endtask

  task automatic tick();
    if (o_ov && s_pr) begin
      dpops++;
      if (gold.size() == 0)
        check("sb_extra", o_od, 32'hdead_beef);
      else
        check("sb_data", o_od, gold.pop_front());
    end
    @(posedge clk);
    if (!reset)
      model_edge();
    @(negedge clk);
    check("pop_valid", 32'(o_ov), 32'(mov));
    if (mov)
      check("pop_payload", o_od, mod);
    check("push_ready", 32'(o_prdy), 32'((sel ? 4 : 16) > mq.size()));
`ifdef STREAM_FIFO_OCCUPANCY_EN
    check("occupancy", o_occ, mq.size() + int'(mov));
`endif
  endtask

  task automatic drain();
    s_pv = 1'b0;
    s_pr = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (!o_ov && !mov && mq.size() == 0)
        break;
      tick();
    end
    check("drain_valid", 32'(o_ov), 0);
    check("drain_gold", gold.size(), 0);
  endtask

  initial begin
    int acc;
    int p0;
    repeat (2) @(negedge clk);
    check("rst_pop_valid", 32'(o_ov), 0);
    check("rst_push_ready", 32'(o_prdy), 1);
`ifdef STREAM_FIFO_OCCUPANCY_EN
    check("rst_occ", o_occ, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // three pushes, consumer always ready
    s_pr = 1'b1;
    s_pv = 1'b1;
    s_pd = 32'hA1;
    tick();
    check("lat_e1", 32'(o_ov), 0);
    s_pd = 32'hA2;
    tick();
    check("lat_e2", 32'(o_ov), 1);
    check("pop_a1", o_od, 32'hA1);
    s_pd = 32'hA3;
    tick();
    check("pop_a2", o_od, 32'hA2);
    s_pv = 1'b0;
    tick();
    check("pop_a3", o_od, 32'hA3);
    tick();
    check("a_done", 32'(o_ov), 0);
    drain();

    // fill with consumer stalled
    s_pr = 1'b0;
    s_pv = 1'b1;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!o_prdy)
        break;
      s_pd = 32'h100 + 32'(acc);
      tick();
      acc++;
    end
    s_pv = 1'b0;
    check("fill_count", acc, 17);
`ifdef STREAM_FIFO_OCCUPANCY_EN
    check("fill_occ", o_occ, 17);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_payload", o_od, 32'h100);
    end

    // one-cycle pop pulse from full
    s_pr = 1'b1;
    tick();
    s_pr = 1'b0;
    check("pulse_ready", 32'(o_prdy), 1);
    s_pv = 1'b1;
    s_pd = 32'h1FF;
    tick();
    s_pv = 1'b0;
    check("refull_ready", 32'(o_prdy), 0);
    drain();

    // continuous streaming
    s_pv = 1'b1;
    s_pr = 1'b1;
    p0 = dpops;
    for (int i = 0; i < 100; i++) begin
      s_pd = $urandom;
      tick();
`ifdef STREAM_FIFO_OCCUPANCY_EN
      if (i >= 2)
        check("stream_occ", o_occ, 2);
`endif
    end
    check("stream_pops", dpops - p0, 98);
    drain();

    // random traffic on the small FIFO
    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10000; i++) begin
      s_pv = 1'($urandom);
      s_pr = 1'($urandom);
      s_pd = $urandom;
      tick();
    end
    drain();
    sel = 1'b0;
    @(negedge clk);

    // reset with five entries held
    s_pr = 1'b0;
    s_pv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_pd = 32'hB0 + 32'(i);
      tick();
    end
    s_pv = 1'b0;
    check("pre_rst_valid", 32'(o_ov), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(o_ov), 0);
    check("mid_rst_ready", 32'(o_prdy), 1);
`ifdef STREAM_FIFO_OCCUPANCY_EN
    check("mid_rst_occ", o_occ, 0);
`endif
    model_clear();
    @(negedge clk);
    tick();
    reset = 1'b0;
    s_pr = 1'b1;
    s_pv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_pd = 32'hC1 + 32'(i);
      tick();
    end
    drain();
    check("post_rst_pops", dpops > 0 ? 32'(gold.size()) : 32'hffff, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
